uart_rx_os16: RTL and testbench



---
 rtl/uart_rx_os16.sv | 149 ++++++++++++++
 tb/tb_uart_rx_os16.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// UART receiver, 8N1, 16x oversampling derived from the core clock.
// Start-bit validation, 3-sample majority per bit, registered one-clock result strobes.
//
// state | meaning
// IDLE  | waiting for a falling edge on an armed, enabled line
// START | confirming the start bit at mid-bit, then aligning to bit boundary
// DATA  | shifting in eight data bits, LSB first
// STOP  | sampling the stop bit; leaves half a bit early to resync on the next start
module uart_rx_os16 #(
    parameter int ClkFreq  = 10_000_000,
    parameter int BaudRate = 115200
) (
    input  logic       clk,
    input  logic       enable,
    input  logic       rx_data,
    input  logic       rx_en,
    output logic [7:0] rx_output_data,
    output logic       rx_output_data_valid,
    output logic       rx_frame_error,
    output logic       rx_busy
);
    localparam int DIV = (ClkFreq + 8 * BaudRate) / (16 * BaudRate);
    localparam int TW  = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic            rx_m_q, rx_s_q;
    logic [1:0]      fill_q;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [3:0]      scnt_q, scnt_d;
    logic [1:0]      smp_q, smp_d;
    logic            armed_q, armed_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            tick, maj, decide, bit_end, start;

    assign tick    = (tcnt_q == TW'(DIV - 1));
    assign decide  = tick && (scnt_q == 4'd9);
    assign bit_end = tick && (scnt_q == 4'd15);
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        start   = 1'b0;
        armed_d = armed_q;
        // Arm only once both synchroniser stages hold real line samples, not reset values.
        if (state_q == IDLE && rx_s_q && fill_q == 2'd2) armed_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (rx_en && armed_q && !rx_s_q) begin
                    state_d = START;
                    start   = 1'b1;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                    bidx_d  = 3'd0;
                end
            end
            DATA: begin
                if (decide) shreg_d = {maj, shreg_q[7:1]};
                if (bit_end) begin
                    if (bidx_q == 3'd7) state_d = STOP;
                    else                bidx_d  = bidx_q + 3'd1;
                end
            end
            STOP: begin
                if (decide) begin
                    state_d = IDLE;
                    if (maj) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !rx_en) begin
            state_d = IDLE;
            data_d  = data_q;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_comb begin
        tcnt_d = tick ? '0 : tcnt_q + TW'(1);
        scnt_d = tick ? scnt_q + 4'd1 : scnt_q;
        smp_d  = smp_q;
        if (tick && scnt_q == 4'd7) smp_d[0] = rx_s_q;
        if (tick && scnt_q == 4'd8) smp_d[1] = rx_s_q;
        if (start) begin
            tcnt_d = '0;
            scnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            state_q <= IDLE;
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            fill_q  <= 2'd0;
            tcnt_q  <= '0;
            scnt_q  <= 4'd0;
            smp_q   <= 2'b00;
            armed_q <= 1'b0;
            bidx_q  <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_m_q  <= rx_data;
            rx_s_q  <= rx_m_q;
            if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            tcnt_q  <= tcnt_d;
            scnt_q  <= scnt_d;
            smp_q   <= smp_d;
            armed_q <= armed_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_output_data       = data_q;
    assign rx_output_data_valid = valid_q;
    assign rx_frame_error       = ferr_q;
    assign rx_busy              = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16 at default parameters (80 clk per bit).
module tb_uart_rx_os16;
    logic       clk = 1'b0;
    logic       enable;
    logic       rx_data;
    logic       rx_en;
    logic [7:0] rx_output_data;
    logic       rx_output_data_valid;
    logic       rx_frame_error;
    logic       rx_busy;

    uart_rx_os16 dut (
        .clk                  (clk),
        .enable               (enable),
        .rx_data              (rx_data),
        .rx_en                (rx_en),
        .rx_output_data       (rx_output_data),
        .rx_output_data_valid (rx_output_data_valid),
        .rx_frame_error       (rx_frame_error),
        .rx_busy              (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   nvalid = 0;
    int   nferr = 0;
    int   mon_errs = 0;
    int   vcyc [16];
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;

    always @(negedge clk) begin
        prev_v   <= rx_output_data_valid;
        prev_f   <= rx_frame_error;
        mon_errs <= mon_errs + int'(rx_output_data_valid && prev_v)
                            + int'(rx_frame_error && prev_f)
                            + int'(rx_output_data_valid && rx_frame_error);
        if (rx_output_data_valid) begin
            nvalid <= nvalid + 1;
            if (nvalid < 16) vcyc[nvalid] <= cyc;
        end
        if (rx_frame_error) nferr <= nferr + 1;
    end

    int total = 0;
    int bad = 0;
    int t_fall = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got=%0d expected range %0d..%0d", name, got, lo, hi);
        end
    endtask

    // act_kind: 0 = 5-clk inverted pulse, 1 = drop rx_en, 2 = pulse reset; applied in frame slot act_pos
    task automatic send_frame(input logic [7:0] d, input logic stp, input int act_pos, input int act_kind);
        logic bv, v;
        for (int pos = 0; pos < 10; pos++) begin
            bv = (pos == 0) ? 1'b0 : (pos == 9) ? stp : d[pos-1];
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                v = bv;
                if (pos == act_pos) begin
                    if (act_kind == 0 && c >= 43 && c < 48) v = ~bv;
                    if (act_kind == 1 && c == 40) rx_en = 1'b0;
                    if (act_kind == 1 && c == 41) check("abort_busy", {31'd0, rx_busy}, 32'd0);
                    if (act_kind == 2 && c == 40) begin
                        enable = 1'b0;
                        #1;
                        check("async_reset_outs",
                              {21'd0, rx_output_data, rx_output_data_valid, rx_frame_error, rx_busy}, 32'd0);
                    end
                    if (act_kind == 2 && c == 60) enable = 1'b1;
                end
                rx_data = v;
                if (pos == 0 && c == 0) t_fall = cyc;
            end
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stp;
        int         gap;
        int         ev;
        int         ef;
        logic [7:0] ed;
    } vec_t;

    vec_t tab [5];
    int   v0, f0;

    initial begin
        tab[0] = '{d: 8'hA5, stp: 1'b1, gap: 100,  ev: 1, ef: 0, ed: 8'hA5};
        tab[1] = '{d: 8'h00, stp: 1'b1, gap: 0,    ev: 1, ef: 0, ed: 8'h00};
        tab[2] = '{d: 8'hFF, stp: 1'b1, gap: 0,    ev: 1, ef: 0, ed: 8'hFF};
        tab[3] = '{d: 8'h3C, stp: 1'b1, gap: 0,    ev: 1, ef: 0, ed: 8'h3C};
        tab[4] = '{d: 8'h55, stp: 1'b0, gap: 2000, ev: 0, ef: 1, ed: 8'h3C};

        enable  = 1'b0;
        rx_data = 1'b1;
        rx_en   = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_outs", {21'd0, rx_output_data, rx_output_data_valid, rx_frame_error, rx_busy}, 32'd0);
        enable = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            v0 = nvalid;
            f0 = nferr;
            send_frame(tab[i].d, tab[i].stp, -1, 0);
            repeat (tab[i].gap) @(negedge clk);
            check($sformatf("vec%0d_valid_count", i), nvalid - v0, tab[i].ev);
            check($sformatf("vec%0d_ferr_count", i), nferr - f0, tab[i].ef);
            check($sformatf("vec%0d_data", i), {24'd0, rx_output_data}, {24'd0, tab[i].ed});
            if (tab[i].gap > 0) check($sformatf("vec%0d_busy_idle", i), {31'd0, rx_busy}, 32'd0);
            if (i == 0) check_range("latency_A5", vcyc[0] - t_fall, 772, 776);
        end
        check("spacing_00_FF", vcyc[2] - vcyc[1], 800);
        check("spacing_FF_3C", vcyc[3] - vcyc[2], 800);

        rx_data = 1'b1;
        repeat (100) @(negedge clk);
        v0 = nvalid;
        send_frame(8'h12, 1'b1, -1, 0);
        repeat (20) @(negedge clk);
        check("after_break_count", nvalid - v0, 1);
        check("after_break_data", {24'd0, rx_output_data}, 32'h12);

        v0 = nvalid;
        f0 = nferr;
        rx_data = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy_started", {31'd0, rx_busy}, 32'd1);
        repeat (10) @(negedge clk);
        rx_data = 1'b1;
        repeat (200) @(negedge clk);
        check("false_start_strobes", (nvalid - v0) + (nferr - f0), 0);
        check("false_start_busy", {31'd0, rx_busy}, 32'd0);

        v0 = nvalid;
        send_frame(8'hF0, 1'b1, 4, 0);
        repeat (20) @(negedge clk);
        check("glitch_frame_count", nvalid - v0, 1);
        check("glitch_frame_data", {24'd0, rx_output_data}, 32'hF0);

        v0 = nvalid;
        f0 = nferr;
        send_frame(8'h81, 1'b1, 5, 1);
        repeat (20) @(negedge clk);
        rx_en = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_strobes", (nvalid - v0) + (nferr - f0), 0);
        check("abort_data_kept", {24'd0, rx_output_data}, 32'hF0);
        send_frame(8'h7E, 1'b1, -1, 0);
        repeat (20) @(negedge clk);
        check("after_abort_count", nvalid - v0, 1);
        check("after_abort_data", {24'd0, rx_output_data}, 32'h7E);

        v0 = nvalid;
        f0 = nferr;
        send_frame(8'h00, 1'b1, 3, 2);
        repeat (200) @(negedge clk);
        check("residual_strobes", (nvalid - v0) + (nferr - f0), 0);
        check("residual_busy", {31'd0, rx_busy}, 32'd0);
        send_frame(8'hC3, 1'b1, -1, 0);
        repeat (20) @(negedge clk);
        check("after_reset_count", nvalid - v0, 1);
        check("after_reset_data", {24'd0, rx_output_data}, 32'hC3);

        repeat (5) @(negedge clk);
        check("strobe_shape_errors", mon_errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
